// File: rtl/spi_slave.sv
`timescale 1ns/1ps
// SPI slave, modes 0-3, MSB first. sclk/ss_n/mosi are resynchronised into clk,
// so rx_valid follows the synchronised sample edge by one clk.
module spi_slave #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] inload,
    input  logic [1:0]       mode,
    input  logic             ss_n,
    input  logic             sclk,
    input  logic             mosi,
    output logic             miso,
    output logic             miso_oe,
    output logic [WIDTH-1:0] slave_sr,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACTIVE = 1'b1;

    logic [2:0]       sclk_sync;
    logic [2:0]       ss_sync;
    logic [1:0]       mosi_sync;
    logic [0:0]       state;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_next;
    logic [CW-1:0]    bit_cnt;
    logic             cpol;
    logic             cpha;
    logic             miso_q;
    logic             sclk_rise;
    logic             sclk_fall;
    logic             ss_fall;
    logic             ss_rise;
    logic             lead_edge;
    logic             trail_edge;
    logic             sample_edge;
    logic             shift_edge;

    // Bits [1] are the synchronised levels; bit [2] is the delayed copy for edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sclk_sync <= 3'b000;
            ss_sync   <= 3'b111;
            mosi_sync <= 2'b00;
        end else begin
            sclk_sync <= {sclk_sync[1:0], sclk};
            ss_sync   <= {ss_sync[1:0], ss_n};
            mosi_sync <= {mosi_sync[0], mosi};
        end
    end

    always_comb begin
        sclk_rise   = sclk_sync[1] & ~sclk_sync[2];
        sclk_fall   = ~sclk_sync[1] & sclk_sync[2];
        ss_fall     = ~ss_sync[1] & ss_sync[2];
        ss_rise     = ss_sync[1] & ~ss_sync[2];
        lead_edge   = cpol ? sclk_fall : sclk_rise;
        trail_edge  = cpol ? sclk_rise : sclk_fall;
        sample_edge = cpha ? trail_edge : lead_edge;
        shift_edge  = cpha ? lead_edge : trail_edge;
        sr_next     = {sr[WIDTH-2:0], mosi_sync[1]};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            sr       <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            miso_q   <= 1'b0;
            bit_cnt  <= '0;
            cpol     <= 1'b0;
            cpha     <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (ss_fall) begin
                        state   <= ACTIVE;
                        cpol    <= mode[1];
                        cpha    <= mode[0];
                        bit_cnt <= '0;
                        if (load) begin
                            sr <= inload;
                        end
                        // cpha=0 has no shift-out edge before the first sample, so preload the MSB.
                        if (!mode[0]) begin
                            miso_q <= load ? inload[WIDTH-1] : sr[WIDTH-1];
                        end
                    end else if (load) begin
                        sr <= inload;
                    end
                end
                default: begin
                    if (ss_rise) begin
                        state   <= IDLE;
                        bit_cnt <= '0;
                    end else if (sample_edge) begin
                        sr <= sr_next;
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt  <= '0;
                            rx_data  <= sr_next;
                            rx_valid <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + CW'(1);
                        end
                    end else if (shift_edge) begin
                        miso_q <= sr[WIDTH-1];
                    end
                end
            endcase
        end
    end

    always_comb begin
        busy     = (state == ACTIVE);
        miso_oe  = busy;
        miso     = busy & miso_q;
        slave_sr = sr;
    end

endmodule

// File: tb/tb_spi_slave.sv
`timescale 1ns/1ps
// Bench for spi_slave: bit-banged SPI master plus a byte-level reference model
// (tx stream = loaded byte then previously received bytes; rx stream = master bytes).
module tb_spi_slave;

    localparam int H = 6;

    logic       clk;
    logic       reset;
    logic       load;
    logic [7:0] inload;
    logic [1:0] mode;
    logic       ss_n;
    logic       sclk;
    logic       mosi;
    logic       miso;
    logic       miso_oe;
    logic [7:0] slave_sr;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;

    logic       cpol_m;
    logic       cpha_m;
    logic [7:0] exp_sr;
    logic [7:0] exp_rx;
    logic [7:0] rx_q[$];
    int         pulse_cnt;
    int         n_checks;
    int         n_fail;

    spi_slave #(.WIDTH(8)) dut (
        .clk(clk), .reset(reset), .load(load), .inload(inload), .mode(mode),
        .ss_n(ss_n), .sclk(sclk), .mosi(mosi), .miso(miso), .miso_oe(miso_oe),
        .slave_sr(slave_sr), .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial pulse_cnt = 0;
    always @(negedge clk) begin
        if (rx_valid) begin
            rx_q.push_back(rx_data);
            pulse_cnt++;
        end
    end

    // Master drives bits hi..lo of tx and returns the miso bits it sampled in the same positions.
    task automatic spi_bits(input logic [7:0] tx, input int hi, input int lo, output logic [7:0] got);
        got = 8'h00;
        for (int i = hi; i >= lo; i--) begin
            if (!cpha_m) begin
                mosi = tx[i];
                repeat (H) @(negedge clk);
                got[i] = miso;
                sclk = ~sclk;
                repeat (H) @(negedge clk);
                sclk = ~sclk;
            end else begin
                sclk = ~sclk;
                mosi = tx[i];
                repeat (H) @(negedge clk);
                got[i] = miso;
                sclk = ~sclk;
                repeat (H) @(negedge clk);
            end
        end
        repeat (H) @(negedge clk);
    endtask

    // at_detect pulses load exactly in the clk where the synchronised ss_n fall is acted on.
    task automatic start_frame(input logic [1:0] m, input bit at_detect, input logic [7:0] v);
        mode   = m;
        cpol_m = m[1];
        cpha_m = m[0];
        sclk   = m[1];
        repeat (6) @(negedge clk);
        ss_n = 1'b0;
        repeat (2) @(negedge clk);
        if (at_detect) begin
            load   = 1'b1;
            inload = v;
        end
        @(negedge clk);
        load = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic end_frame();
        ss_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic do_load(input logic [7:0] v);
        load   = 1'b1;
        inload = v;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_checks++; if (miso_oe !== 1'b0) begin n_fail++; $display("FAIL reset_miso_oe got=%b exp=0", miso_oe); end
        n_checks++; if (miso !== 1'b0) begin n_fail++; $display("FAIL reset_miso got=%b exp=0", miso); end
        n_checks++; if (slave_sr !== 8'h00) begin n_fail++; $display("FAIL reset_sr got=%h exp=00", slave_sr); end
        n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx got=%h exp=00", rx_data); end
        n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid got=%b exp=0", rx_valid); end
        reset = 1'b1;
        repeat (4) @(negedge clk);
        exp_sr = 8'h00;
        exp_rx = 8'h00;
    endtask

    task automatic test_mode0();
        logic [7:0] got;
        int base;
        base = pulse_cnt;
        do_load(8'hE9);
        start_frame(2'b00, 1'b0, 8'h00);
        n_checks++; if (busy !== 1'b1 || miso_oe !== 1'b1) begin n_fail++; $display("FAIL m0_active busy=%b oe=%b exp=1,1", busy, miso_oe); end
        spi_bits(8'hA5, 7, 0, got);
        end_frame();
        n_checks++; if (got !== 8'hE9) begin n_fail++; $display("FAIL m0_miso got=%h exp=e9", got); end
        n_checks++; if (pulse_cnt - base !== 1) begin n_fail++; $display("FAIL m0_pulses got=%0d exp=1", pulse_cnt - base); end
        n_checks++; if (rx_data !== 8'hA5) begin n_fail++; $display("FAIL m0_rx got=%h exp=a5", rx_data); end
        n_checks++; if (slave_sr !== 8'hA5) begin n_fail++; $display("FAIL m0_sr got=%h exp=a5", slave_sr); end
        n_checks++; if (busy !== 1'b0 || miso_oe !== 1'b0) begin n_fail++; $display("FAIL m0_idle busy=%b oe=%b exp=0,0", busy, miso_oe); end
        exp_sr = 8'hA5;
        exp_rx = 8'hA5;
    endtask

    task automatic test_mode3();
        logic [7:0] got;
        int base;
        base = pulse_cnt;
        do_load(8'hF0);
        start_frame(2'b11, 1'b0, 8'h00);
        spi_bits(8'h0F, 7, 0, got);
        end_frame();
        n_checks++; if (got !== 8'hF0) begin n_fail++; $display("FAIL m3_miso got=%h exp=f0", got); end
        n_checks++; if (pulse_cnt - base !== 1) begin n_fail++; $display("FAIL m3_pulses got=%0d exp=1", pulse_cnt - base); end
        n_checks++; if (rx_data !== 8'h0F) begin n_fail++; $display("FAIL m3_rx got=%h exp=0f", rx_data); end
        exp_sr = 8'h0F;
        exp_rx = 8'h0F;
    endtask

    task automatic test_back_to_back();
        logic [7:0] g0;
        logic [7:0] g1;
        int base;
        base = pulse_cnt;
        do_load(8'h99);
        start_frame(2'b01, 1'b0, 8'h00);
        spi_bits(8'h3C, 7, 0, g0);
        spi_bits(8'hC3, 7, 0, g1);
        end_frame();
        n_checks++; if (g0 !== 8'h99) begin n_fail++; $display("FAIL b2b_miso0 got=%h exp=99", g0); end
        n_checks++; if (g1 !== 8'h3C) begin n_fail++; $display("FAIL b2b_miso1 got=%h exp=3c", g1); end
        n_checks++; if (pulse_cnt - base !== 2) begin n_fail++; $display("FAIL b2b_pulses got=%0d exp=2", pulse_cnt - base); end
        n_checks++; if ((rx_q.size() > base ? rx_q[base] : 8'hxx) !== 8'h3C) begin n_fail++; $display("FAIL b2b_rx0 got=%h exp=3c", rx_q.size() > base ? rx_q[base] : 8'hxx); end
        n_checks++; if ((rx_q.size() > base + 1 ? rx_q[base+1] : 8'hxx) !== 8'hC3) begin n_fail++; $display("FAIL b2b_rx1 got=%h exp=c3", rx_q.size() > base + 1 ? rx_q[base+1] : 8'hxx); end
        exp_sr = 8'hC3;
        exp_rx = 8'hC3;
    endtask

    task automatic test_abort();
        logic [7:0] got;
        logic [7:0] partial;
        int base;
        base = pulse_cnt;
        do_load(8'h0F);
        start_frame(2'b10, 1'b0, 8'h00);
        spi_bits(8'hB7, 7, 3, got);
        end_frame();
        partial = 8'((16'h000F << 5) | (16'h00B7 >> 3));
        n_checks++; if (pulse_cnt - base !== 0) begin n_fail++; $display("FAIL abort_pulses got=%0d exp=0", pulse_cnt - base); end
        n_checks++; if (busy !== 1'b0 || miso_oe !== 1'b0) begin n_fail++; $display("FAIL abort_idle busy=%b oe=%b exp=0,0", busy, miso_oe); end
        n_checks++; if (rx_data !== exp_rx) begin n_fail++; $display("FAIL abort_rx got=%h exp=%h", rx_data, exp_rx); end
        n_checks++; if (slave_sr !== partial) begin n_fail++; $display("FAIL abort_sr got=%h exp=%h", slave_sr, partial); end
        n_checks++; if (got[7:3] !== 5'b00001) begin n_fail++; $display("FAIL abort_miso got=%b exp=00001", got[7:3]); end
        base = pulse_cnt;
        do_load(8'h6B);
        start_frame(2'b10, 1'b0, 8'h00);
        spi_bits(8'h5A, 7, 0, got);
        end_frame();
        n_checks++; if (got !== 8'h6B) begin n_fail++; $display("FAIL abort_next_miso got=%h exp=6b", got); end
        n_checks++; if (pulse_cnt - base !== 1 || rx_data !== 8'h5A) begin n_fail++; $display("FAIL abort_next_rx pulses=%0d rx=%h exp=1,5a", pulse_cnt - base, rx_data); end
        exp_sr = 8'h5A;
        exp_rx = 8'h5A;
    endtask

    task automatic test_active_ignore();
        logic [7:0] ga;
        logic [7:0] gb;
        int base;
        base = pulse_cnt;
        do_load(8'h81);
        start_frame(2'b00, 1'b0, 8'h00);
        spi_bits(8'h42, 7, 4, ga);
        load   = 1'b1;
        inload = 8'hFF;
        mode   = 2'b11;
        @(negedge clk);
        load = 1'b0;
        spi_bits(8'h42, 3, 0, gb);
        end_frame();
        mode = 2'b00;
        n_checks++; if ((ga | gb) !== 8'h81) begin n_fail++; $display("FAIL ignore_miso got=%h exp=81", ga | gb); end
        n_checks++; if (pulse_cnt - base !== 1 || rx_data !== 8'h42) begin n_fail++; $display("FAIL ignore_rx pulses=%0d rx=%h exp=1,42", pulse_cnt - base, rx_data); end
        n_checks++; if (slave_sr !== 8'h42) begin n_fail++; $display("FAIL ignore_sr got=%h exp=42", slave_sr); end
        exp_sr = 8'h42;
        exp_rx = 8'h42;
    endtask

    task automatic test_reset_midframe();
        logic [7:0] got;
        int base;
        do_load(8'hFF);
        start_frame(2'b00, 1'b0, 8'h00);
        spi_bits(8'hE0, 7, 5, got);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0 || miso_oe !== 1'b0 || miso !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ctl busy=%b oe=%b miso=%b exp=0,0,0", busy, miso_oe, miso); end
        n_checks++; if (slave_sr !== 8'h00 || rx_data !== 8'h00 || rx_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_data sr=%h rx=%h vld=%b exp=00,00,0", slave_sr, rx_data, rx_valid); end
        ss_n = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        base = pulse_cnt;
        for (int i = 0; i < 8; i++) begin
            mosi = 1'b1;
            sclk = ~sclk;
            repeat (H) @(negedge clk);
        end
        n_checks++; if (busy !== 1'b0 || slave_sr !== 8'h00 || pulse_cnt - base !== 0) begin n_fail++; $display("FAIL rst_idle_sclk busy=%b sr=%h pulses=%0d exp=0,00,0", busy, slave_sr, pulse_cnt - base); end
        exp_sr = 8'h00;
        exp_rx = 8'h00;
    endtask

    task automatic test_random();
        logic [1:0] m;
        logic [7:0] ld;
        logic [7:0] got;
        logic [7:0] tx[3];
        logic [7:0] exp_miso;
        int nb;
        int base;
        bit at_detect;
        for (int f = 0; f < 16; f++) begin
            m         = 2'($urandom_range(0, 3));
            ld        = 8'($urandom);
            nb        = $urandom_range(1, 3);
            at_detect = 1'($urandom_range(0, 1));
            for (int k = 0; k < 3; k++) tx[k] = 8'($urandom);
            sclk = ~sclk;
            repeat (H) @(negedge clk);
            sclk = ~sclk;
            repeat (H) @(negedge clk);
            n_checks++; if (slave_sr !== exp_sr) begin n_fail++; $display("FAIL rnd%0d_idle_sr got=%h exp=%h", f, slave_sr, exp_sr); end
            base = pulse_cnt;
            if (!at_detect) do_load(ld);
            start_frame(m, at_detect, ld);
            for (int k = 0; k < nb; k++) begin
                spi_bits(tx[k], 7, 0, got);
                exp_miso = (k == 0) ? ld : tx[k-1];
                n_checks++; if (got !== exp_miso) begin n_fail++; $display("FAIL rnd%0d_b%0d_miso mode=%0d got=%h exp=%h", f, k, m, got, exp_miso); end
            end
            end_frame();
            n_checks++; if (pulse_cnt - base !== nb) begin n_fail++; $display("FAIL rnd%0d_pulses got=%0d exp=%0d", f, pulse_cnt - base, nb); end
            for (int k = 0; k < nb; k++) begin
                n_checks++; if ((rx_q.size() > base + k ? rx_q[base+k] : 8'hxx) !== tx[k]) begin n_fail++; $display("FAIL rnd%0d_rx%0d got=%h exp=%h", f, k, rx_q.size() > base + k ? rx_q[base+k] : 8'hxx, tx[k]); end
            end
            exp_sr = tx[nb-1];
            exp_rx = tx[nb-1];
            n_checks++; if (slave_sr !== exp_sr || rx_data !== exp_rx) begin n_fail++; $display("FAIL rnd%0d_final sr=%h rx=%h exp=%h", f, slave_sr, rx_data, exp_sr); end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        load     = 1'b0;
        inload   = 8'h00;
        mode     = 2'b00;
        ss_n     = 1'b1;
        sclk     = 1'b0;
        mosi     = 1'b0;
        cpol_m   = 1'b0;
        cpha_m   = 1'b0;
        exp_sr   = 8'h00;
        exp_rx   = 8'h00;
        test_reset();
        test_mode0();
        test_mode3();
        test_back_to_back();
        test_abort();
        test_active_ignore();
        test_reset_midframe();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 Parameter: WIDTH, 8, frame length in bits and width of all data ports.
REQ-002 Port: clk  input  1  system clock; all state changes on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset; the block is in reset while reset=0.
REQ-004 Port: load  input  1  capture inload into shift register (IDLE only).
REQ-005 Port: inload  input  WIDTH  transmit byte for next frame.
REQ-006 Port: mode  input  2  SPI mode {CPOL,CPHA}, latched at frame start.
REQ-007 Port: ss_n  input  1  slave select from master, active-low, asynchronous to clk.
REQ-008 Port: sclk  input  1  serial clock from master, asynchronous to clk.
REQ-009 Port: mosi  input  1  serial data from master.
REQ-010 Port: miso  output  1  serial data to master, MSB first.
REQ-011 Port: miso_oe  output  1  miso drive enable, 1 while frame active.
REQ-012 Port: slave_sr  output  WIDTH  live shift-register contents.
REQ-013 Port: rx_data  output  WIDTH  last complete received byte.
REQ-014 Port: rx_valid  output  1  one-cycle pulse when rx_data updates.
REQ-015 Port: busy  output  1  1 while in ACTIVE state.

Function
REQ-016 sclk, ss_n, mosi SHALL each pass through a 2-flop synchronizer; edges detected against a third registered copy of sclk/ss_n.
REQ-017 Correct operation SHALL require sclk high and low phases of at least 4 clk periods each; mosi stable across sample edge.
REQ-018 States SHALL be IDLE and ACTIVE; IDLE->ACTIVE on synchronized ss_n falling edge; ACTIVE->IDLE on synchronized ss_n rising edge.
REQ-019 On IDLE->ACTIVE: mode latched into cpol/cpha registers, bit_cnt cleared, miso_oe=1, busy=1; mode changes while ACTIVE SHALL be ignored.
REQ-020 Leading edge = sclk rising if cpol=0, falling if cpol=1; trailing edge = opposite.
REQ-021 Sample edge = leading if cpha=0, trailing if cpha=1; shift-out edge = the other.
REQ-022 Sample edge: sr <= {sr[WIDTH-2:0], mosi}; bit_cnt increments.
REQ-023 Shift-out edge: miso_q <= sr[WIDTH-1]; miso = miso_q while ACTIVE, 0 while IDLE.
REQ-024 cpha=0: miso_q SHALL be loaded with sr[WIDTH-1] at frame start so the first bit is valid before the first leading edge.
REQ-025 When bit_cnt reaches WIDTH: rx_data <= new sr value, rx_valid=1 for exactly one clk, bit_cnt <= 0; latency from synchronized sample edge to rx_valid = 1 clk.
REQ-026 Back-to-back bytes without ss_n deassertion SHALL be received continuously; next byte transmitted = sr contents (last received byte unless reloaded).
REQ-027 load=1 in IDLE: sr <= inload next clk; load while ACTIVE SHALL be ignored.
REQ-028 load in the same clk as frame-start detection: sr and (cpha=0) miso_q SHALL take inload.
REQ-029 ss_n rising mid-byte (abort): return to IDLE, bit_cnt=0, no rx_valid, rx_data unchanged, sr keeps partial contents, miso_oe=0.
REQ-030 sclk edges while IDLE SHALL have no effect.

Reset
REQ-031 reset=0 SHALL immediately force: state IDLE, sr=0, rx_data=0, rx_valid=0, miso_q=0, miso=0, miso_oe=0, busy=0, bit_cnt=0, cpol=cpha=0.
REQ-032 Synchronizer/edge flops: ss_n copies reset to 1, sclk and mosi copies reset to 0.
REQ-033 Reset asserted mid-frame SHALL discard the frame; after release a new ss_n falling edge is needed to start.

Verification
REQ-034 Mode 0, load 0xE9, master sends 0xA5 -> miso bits 1,1,1,0,1,0,0,1; rx_data=0xA5, single rx_valid pulse, slave_sr=0xA5.
REQ-035 Mode 3, load 0xF0, master sends 0x0F -> miso 1,1,1,1,0,0,0,0 sampled on rising edges; rx_data=0x0F.
REQ-036 Mode 1, load 0x99, two bytes 0x3C,0xC3 under one ss_n low -> two rx_valid pulses, rx_data 0x3C then 0xC3; second-byte miso = 0x3C.
REQ-037 Mode 2, ss_n high after 5 bits -> no rx_valid, busy=0, miso_oe=0; following full frame 0x5A received correctly.
REQ-038 reset=0 after 3 bits of mode 0 frame -> all outputs 0 within same cycle; load during ACTIVE or mode change mid-frame -> no effect on current frame.
